// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared types and helpers for the data-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  // Access sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Width of each per-requester grant counter
  localparam int CNT_W = 16;

  // Low bit of requester idx's field in a flattened bus of w-bit fields
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin picker. Returns the first set bit of
//           elig, searching upward from last_grant+1 and wrapping modulo
//           N_REQ (N_REQ need not be a power of two).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [IDX_W-1:0] idx;

  // Walk the search order farthest-first so the nearest candidate wins last
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin arbiter sharing one synchronous DataMemory port among
//           N_REQ requesters. Each access runs IDLE -> ISSUE -> RESP, with a
//           one-cycle one-hot ack in the cycle after RESP.
//           Optional: define DMEM_ARB_STATS_EN to add saturating per-requester
//           grant counters on output grant_cnt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]  grant_cnt
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0]    ack_q, ack_d;

  logic [N_REQ-1:0]    elig;
  logic [IDX_W-1:0]    pick;
  logic                pick_found;

  // A requester being acked this cycle is not yet re-requesting
  assign elig = req & ~ack_q;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .elig       (elig),
    .last_grant (last_grant_q),
    .winner     (pick),
    .found      (pick_found)
  );

  // Next-state, access latching and response capture
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          winner_d = pick;
          we_d     = we[pick];
          addr_d   = addr[slice_lo(int'(pick), ADDR_W) +: ADDR_W];
          wdata_d  = wdata[slice_lo(int'(pick), DATA_W) +: DATA_W];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        // Read data is valid now: one cycle after ISSUE presented the address
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
        ack_d[winner_q] = 1'b1;
        last_grant_d    = winner_q;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight access without an ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      last_grant_q <= LAST_IDX;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign busy      = (state_q != IDLE);

`ifdef DMEM_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count acks, sticking at all-ones
    always_comb begin
      cnt_d = cnt_q;
      if (ack_q[i] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter sharing the single DataMemory port between N_REQ requesters (SMCore instances or their MemoryController_NCores outputs).
- Sequences each access through a fixed 3-state FSM: arbitrate, issue, respond.
- Sits between the requesters and DataMemory in the multi-SM top level and replaces the direct SMCore-to-DataMemory wiring.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, data memory address width; top level overrides with `DATAMEM_ADDR_WIDTH.
- DATA_W, 16, data word width; top level overrides with `DATA_WORD_LENGTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  N_REQ  per-requester access request; level, held until ack.
- we  in  N_REQ  per-requester write enable (1 = write, 0 = read).
- addr  in  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  flattened write data, same packing as addr.
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  read data, broadcast to all requesters; valid while ack is high.
- mem_addr  out  ADDR_W  to DataMemory Address.
- mem_wdata  out  DATA_W  to DataMemory DataToWrite.
- mem_we  out  1  to DataMemory WrEn.
- mem_rdata  in  DATA_W  from DataMemory DataToRead; synchronous read, valid 1 cycle after the address is presented.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset = 0, at any time including mid-access):
  - state = IDLE; ack = 0; rdata = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; busy = 0.
  - last_grant = N_REQ-1, so requester 0 has top priority first.
  - An in-flight access is abandoned with no ack.
- Eligibility: elig = req & ~ack. A requester whose ack is high this cycle is masked for this cycle only.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If elig == 0, stay in IDLE.
  - Otherwise the winner is the first set bit of elig searching last_grant+1, last_grant+2, … modulo N_REQ.
  - Latch the winner index plus its we, addr and wdata; go to ISSUE.
- ISSUE:
  - mem_addr and mem_wdata come from the latched values; mem_we = latched we. This is the only state with mem_we = 1.
  - Go to RESP.
- RESP:
  - mem_addr is held and mem_we = 0.
  - At the edge: rdata <= mem_rdata for a read; rdata holds its previous value for a write.
  - At the edge: ack[winner] <= 1 for exactly one cycle; last_grant <= winner; go to IDLE.
- Latency: req sampled in IDLE at cycle 0 gives ack high in cycle 3. Throughput is one access per 3 cycles; back-to-back grants run IDLE→ISSUE→RESP→IDLE with no bubble beyond IDLE.
- Requester contract:
  - Hold req, we, addr and wdata stable until ack is seen.
  - req still high in the cycle after ack is a new request.
  - Inputs from non-winners may change freely.
- Fairness: with all req high, grants rotate 0,1,…,N_REQ-1,0. A continuously requesting master waits at most N_REQ-1 grants.
- Simultaneous events: a new req arriving during ISSUE or RESP is considered only in the next IDLE. Dropping req after grant does not cancel the access; it completes and acks.
- Widths: the winner index is $clog2(N_REQ) bits. Wrap-around in the priority search is modulo N_REQ, not a power of 2.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds output grant_cnt (N_REQ*16 bits, flattened per requester).
  - Each requester's 16-bit counter increments on its ack and saturates at 0xFFFF.
  - Cleared by reset only.
- Not defined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - State enum arb_state_t {IDLE, ISSUE, RESP}, 2 bits.
  - Localparam for the counter width (16).
  - Helper function for the flattened-slice index.
- Sub-module rr_picker: combinational; inputs elig and last_grant, outputs winner index and a found flag. Reusable by future instruction-fetch arbitration.

Test Plan:
- Reset mid-access: assert reset (0) during ISSUE of a write → mem_we drops to 0 immediately, no ack, next grant goes to requester 0.
- Single read: preload RAM[5] = 0x1234; req[2] = 1, we = 0, addr = 5 at cycle 0 → mem_addr = 5 in cycle 1; ack = 0b0100 and rdata = 0x1234 in cycle 3.
- Single write: req[0] with addr = 3, wdata = 0x00AB → mem_we high only in cycle 1; RAM[3] = 0x00AB; ack[0] in cycle 3.
- Fairness: all four req held high, each re-requesting after ack → ack order 0,1,2,3,0,1 with acks spaced 3 cycles apart.
- Ack masking: requester 1 keeps req high through its ack while requester 3 also requests → requester 3 is granted next, not requester 1.
- Stats (DMEM_ARB_STATS_EN): 5 grants to requester 1 → grant_cnt slice 1 = 5, other slices 0.
